uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Sequences the single UART transmitter between two requesters. The first is the echo path: single received bytes are sent back to the host. The second is the status-message path: a fixed-length string is read byte-by-byte from the TX data memory. The block sits between mode control / RX logic and the UART TX + baud generator, and owns the start/busy handshake with the transmitter.

Parameters:
MSG_LEN, 8, number of bytes in one status message (1..2**ADDR_W)
ADDR_W, 3, width of the message memory address
ACK_TMO, 15, max cycles to wait for iTX_busy to rise after oTX_start before treating the byte as sent

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
iECHO_valid  input  1  one-cycle strobe: iECHO_data holds a byte to echo
iECHO_data  input  8  byte to echo
iMSG_req  input  1  one-cycle strobe: send the status message
oMSG_addr  output  ADDR_W  message memory read address
iMSG_data  input  8  memory read data, valid 1 cycle after oMSG_addr changes
oTX_start  output  1  one-cycle start strobe to the UART TX
oTX_data  output  8  byte to transmit; stable from oTX_start until iTX_busy falls
iTX_busy  input  1  high while the UART TX is shifting a frame
oBusy  output  1  high whenever state != IDLE or a request is pending
oECHO_ovf  output  1  one-cycle pulse: an echo byte was dropped
oMSG_done  output  1  one-cycle pulse after the last message byte completes

Behaviour:
- Reset (sync, active-high, wins over every input): state=IDLE, echo buffer empty, msg_active=0, msg_idx=0, last_grant=MSG. All outputs are 0.
- Echo buffer: 1 entry (echo_full, echo_byte).
  - iECHO_valid with buffer empty → capture the byte, echo_full=1 on the next cycle.
  - iECHO_valid with buffer full and not being granted this cycle → byte dropped, oECHO_ovf=1 for 1 cycle.
  - iECHO_valid in the same cycle the buffer is granted → new byte captured, buffer stays full.
- Message request:
  - iMSG_req while msg_active=0 → msg_active=1, msg_idx=0.
  - iMSG_req while msg_active=1 → ignored (no restart, no queueing).
- FSM states: IDLE, MSG_RD, LOAD, START, WAIT_ACK, WAIT_DONE.
  - IDLE: arbitrates when at least one requester is pending (echo_full or msg_active).
    - Only one pending → grant it.
    - Both pending → grant the one not in last_grant (round-robin per byte). Echo bytes may therefore interleave between message bytes.
    - Echo grant → oTX_data=echo_byte, echo_full cleared, go to START.
    - Message grant → oMSG_addr=msg_idx, go to MSG_RD.
  - MSG_RD: 1-cycle memory latency; go to LOAD.
  - LOAD: oTX_data=iMSG_data; go to START.
  - START: oTX_start=1 for exactly 1 cycle; timeout counter cleared; go to WAIT_ACK.
  - WAIT_ACK: iTX_busy=1 → WAIT_DONE. Counter reaching ACK_TMO → byte treated as complete (same completion action as WAIT_DONE).
  - WAIT_DONE: iTX_busy=0 → byte complete → IDLE.
- On message byte completion:
  - msg_idx increments.
  - If msg_idx was MSG_LEN-1: msg_idx=0, msg_active=0, oMSG_done=1 for 1 cycle.
- last_grant updates on every grant. oTX_data holds its value from LOAD/IDLE until the next load.
- Minimum cycle count:
  - Echo grant → oTX_start: 1 cycle.
  - Message grant → oTX_start: 3 cycles.
- oBusy is combinational from the registered state and the pending flags.
- Reset mid-frame: the FSM returns to IDLE and pending requests are discarded. The UART TX is reset by the same reset.

Test Plan:
1. Reset → every output 0 and oBusy=0. Hold reset 3 cycles while strobing iECHO_valid and iMSG_req → no oTX_start after release.
2. iECHO_valid with 0x41, TX model busy for 20 cycles starting 2 cycles after start → exactly one oTX_start, 1 cycle after capture, with oTX_data=0x41 held until busy falls; oBusy returns to 0.
3. iMSG_req, memory holding "RATE=01\n" (MSG_LEN=8) → 8 starts with bytes 0x52,0x41,0x54,0x45,0x3D,0x30,0x31,0x0A in order; oMSG_done pulses once after the 8th busy fall; oMSG_addr wraps to 0.
4. Message in progress at byte 2, then iECHO_valid 0x58 → transmitted order is msg[0], msg[1], 0x58, msg[2].., with alternating grants while both are pending.
5. Three iECHO_valid strobes (0x31, 0x32, 0x33) during one busy frame → 0x31 transmitted; 0x32 buffered; 0x33 dropped with oECHO_ovf=1 for 1 cycle.
6. TX model never raises busy → each byte completes after ACK_TMO+1 cycles in WAIT_ACK and the message still finishes with oMSG_done. A second iMSG_req mid-message is ignored, so only 8 bytes are sent.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between the UART TX scheduler, its two requesters, the
// status-message memory and the UART transmitter.
interface uart_tx_scheduler_if #(
    parameter int ADDR_W = 3
);
    logic              iECHO_valid;
    logic [7:0]        iECHO_data;
    logic              iMSG_req;
    logic [ADDR_W-1:0] oMSG_addr;
    logic [7:0]        iMSG_data;
    logic              oTX_start;
    logic [7:0]        oTX_data;
    logic              iTX_busy;
    logic              oBusy;
    logic              oECHO_ovf;
    logic              oMSG_done;

    modport master (
        input  iECHO_valid, iECHO_data, iMSG_req, iMSG_data, iTX_busy,
        output oMSG_addr, oTX_start, oTX_data, oBusy, oECHO_ovf, oMSG_done
    );

    modport slave (
        output iECHO_valid, iECHO_data, iMSG_req, iMSG_data, iTX_busy,
        input  oMSG_addr, oTX_start, oTX_data, oBusy, oECHO_ovf, oMSG_done
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a 1-entry echo buffer and a fixed-length
// status message read from memory, round-robin per byte.
module uart_tx_scheduler #(
    parameter int MSG_LEN = 8,
    parameter int ADDR_W  = 3,
    parameter int ACK_TMO = 15
) (
    input logic                 clk,
    input logic                 reset,
    uart_tx_scheduler_if.master bus
);
    localparam int CNT_W = (ACK_TMO > 0) ? $clog2(ACK_TMO + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0]  TMO      = CNT_W'(ACK_TMO);

    typedef enum logic [2:0] {
        IDLE, MSG_RD, LOAD, START, WAIT_ACK, WAIT_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              echo_full;
    logic [7:0]        echo_byte;
    logic              msg_active;
    logic [ADDR_W-1:0] msg_idx;
    logic              last_msg;
    logic              cur_msg;
    logic [CNT_W-1:0]  ack_cnt;
    logic [ADDR_W-1:0] msg_addr;
    logic [7:0]        tx_data;
    logic              echo_ovf;
    logic              msg_done;
    logic              grant_echo;
    logic              grant_msg;
    logic              byte_done;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_echo = 1'b0;
        grant_msg  = 1'b0;
        byte_done  = 1'b0;
        case (state)
            IDLE: begin
                // With both pending, echo wins only if the message had the last grant
                if (echo_full && (!msg_active || last_msg)) begin
                    grant_echo = 1'b1;
                    state_nxt  = START;
                end else if (msg_active) begin
                    grant_msg = 1'b1;
                    state_nxt = MSG_RD;
                end
            end
            MSG_RD:   state_nxt = LOAD;
            LOAD:     state_nxt = START;
            START:    state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.iTX_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt == TMO) begin
                    byte_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.iTX_busy) begin
                    byte_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_full  <= 1'b0;
            echo_byte  <= '0;
            msg_active <= 1'b0;
            msg_idx    <= '0;
            last_msg   <= 1'b1;
            cur_msg    <= 1'b0;
            ack_cnt    <= '0;
            msg_addr   <= '0;
            tx_data    <= '0;
            echo_ovf   <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            echo_ovf <= 1'b0;
            msg_done <= 1'b0;

            // A byte arriving in the grant cycle refills the buffer being emptied
            if (bus.iECHO_valid) begin
                if (!echo_full || grant_echo) begin
                    echo_byte <= bus.iECHO_data;
                    echo_full <= 1'b1;
                end else begin
                    echo_ovf <= 1'b1;
                end
            end else if (grant_echo) begin
                echo_full <= 1'b0;
            end

            if (grant_echo) begin
                tx_data  <= echo_byte;
                last_msg <= 1'b0;
                cur_msg  <= 1'b0;
            end
            if (grant_msg) begin
                msg_addr <= msg_idx;
                last_msg <= 1'b1;
                cur_msg  <= 1'b1;
            end
            if (state == LOAD) tx_data <= bus.iMSG_data;

            if (state == START)         ack_cnt <= '0;
            else if (state == WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;

            if (byte_done && cur_msg) begin
                if (msg_idx == LAST_IDX) begin
                    msg_idx    <= '0;
                    msg_addr   <= '0;
                    msg_active <= 1'b0;
                    msg_done   <= 1'b1;
                end else begin
                    msg_idx <= msg_idx + 1'b1;
                end
            end else if (bus.iMSG_req && !msg_active) begin
                msg_active <= 1'b1;
                msg_idx    <= '0;
            end
        end
    end

    assign bus.oMSG_addr = msg_addr;
    assign bus.oTX_start = (state == START);
    assign bus.oTX_data  = tx_data;
    assign bus.oBusy     = (state != IDLE) || echo_full || msg_active;
    assign bus.oECHO_ovf = echo_ovf;
    assign bus.oMSG_done = msg_done;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: per-cycle vector table with a manually
// driven busy line, then message/echo sequences against a small UART TX model.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef enum int { MANUAL, MODEL, NEVER } tx_mode_t;
    tx_mode_t tx_mode = MANUAL;
    logic     man_busy = 1'b0;
    int       tx_cnt = 0;
    logic     model_busy;

    logic [7:0] mem [8];
    logic [7:0] mem_q = '0;

    logic [7:0] tx_log [$];
    int         start_cyc [$];
    logic [7:0] cur_byte = '0;
    int         done_cnt = 0;

    uart_tx_scheduler_if #(.ADDR_W(3)) bus();

    uart_tx_scheduler #(.MSG_LEN(8), .ADDR_W(3), .ACK_TMO(15)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) mem_q <= mem[bus.oMSG_addr];
    assign bus.iMSG_data = mem_q;

    // TX model: busy rises 2 cycles after the start strobe and stays high 20 cycles
    always @(negedge clk) begin
        if (tx_mode != MODEL || rst)           tx_cnt <= 0;
        else if (bus.oTX_start)                tx_cnt <= 1;
        else if (tx_cnt != 0 && tx_cnt < 23)   tx_cnt <= tx_cnt + 1;
        else                                   tx_cnt <= 0;
    end
    assign model_busy   = (tx_cnt >= 3) && (tx_cnt <= 22);
    assign bus.iTX_busy = (tx_mode == MANUAL) ? man_busy : model_busy;

    always @(negedge clk) begin
        if (!rst && bus.oTX_start) begin
            tx_log.push_back(bus.oTX_data);
            start_cyc.push_back(cyc);
            cur_byte = bus.oTX_data;
        end
        if (!rst && bus.oMSG_done) done_cnt = done_cnt + 1;
    end

    typedef struct packed {
        logic       rst;
        logic       ev;
        logic [7:0] ed;
        logic       mreq;
        logic       busy;
        logic       s;
        logic [7:0] d;
        logic       b;
        logic       o;
    } vec_t;

    vec_t vq [$];

    function automatic vec_t v(input logic r, input logic ev, input logic [7:0] ed,
                               input logic mreq, input logic busy, input logic s,
                               input logic [7:0] d, input logic b, input logic o);
        vec_t x;
        x.rst = r; x.ev = ev; x.ed = ed; x.mreq = mreq; x.busy = busy;
        x.s = s; x.d = d; x.b = b; x.o = o;
        return x;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (model_busy) check("tx_data_hold", {24'd0, bus.oTX_data}, {24'd0, cur_byte});
    endtask

    task automatic strobe_echo(input logic [7:0] b);
        bus.iECHO_valid = 1'b1;
        bus.iECHO_data  = b;
        tick();
        bus.iECHO_valid = 1'b0;
    endtask

    task automatic strobe_msg();
        bus.iMSG_req = 1'b1;
        tick();
        bus.iMSG_req = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int i = 0;
        while (tx_log.size() < n && i < budget) begin tick(); i++; end
        check(nm, {31'd0, tx_log.size() >= n}, 32'd1);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int i = 0;
        while (bus.oMSG_done !== 1'b1 && i < budget) begin tick(); i++; end
        check(nm, {31'd0, bus.oMSG_done}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int i = 0;
        while (bus.oBusy !== 1'b0 && i < budget) begin tick(); i++; end
        check(nm, {31'd0, bus.oBusy}, 32'd0);
    endtask

    initial begin
        logic [7:0] msg_exp [8];
        logic [7:0] c_exp [9];
        int base, dbase, k;

        mem[0] = 8'h52; mem[1] = 8'h41; mem[2] = 8'h54; mem[3] = 8'h45;
        mem[4] = 8'h3D; mem[5] = 8'h30; mem[6] = 8'h31; mem[7] = 8'h0A;
        for (int unsigned i = 0; i < 8; i++) msg_exp[i] = mem[i];
        c_exp[0] = 8'h52; c_exp[1] = 8'h41; c_exp[2] = 8'h58;
        for (int unsigned i = 3; i < 9; i++) c_exp[i] = mem[i-1];

        rst = 1'b1;
        bus.iECHO_valid = 1'b0;
        bus.iECHO_data  = '0;
        bus.iMSG_req    = 1'b0;

        //              rst ev  ed     mreq busy s  d      b  o
        vq.push_back(v(1, 1, 8'hAA, 1, 0,   0, 8'h00, 0, 0));
        vq.push_back(v(1, 1, 8'hAA, 1, 0,   0, 8'h00, 0, 0));
        vq.push_back(v(1, 1, 8'hAA, 1, 0,   0, 8'h00, 0, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0));
        vq.push_back(v(0, 1, 8'h41, 0, 0,   0, 8'h00, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   1, 8'h41, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h41, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h41, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h41, 0, 0));
        vq.push_back(v(0, 1, 8'h31, 0, 0,   0, 8'h41, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   1, 8'h31, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h31, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h31, 1, 0));
        vq.push_back(v(0, 1, 8'h32, 0, 1,   0, 8'h31, 1, 0));
        vq.push_back(v(0, 1, 8'h33, 0, 1,   0, 8'h31, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h31, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h31, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   1, 8'h32, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h32, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h32, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h32, 0, 0));
        vq.push_back(v(0, 1, 8'h50, 0, 0,   0, 8'h32, 1, 0));
        vq.push_back(v(0, 1, 8'h51, 0, 0,   1, 8'h50, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h50, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h50, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h50, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   1, 8'h51, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h51, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 1,   0, 8'h51, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h51, 0, 0));
        vq.push_back(v(0, 1, 8'h60, 0, 0,   0, 8'h51, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   1, 8'h60, 1, 0));
        vq.push_back(v(0, 0, 8'h00, 1, 1,   0, 8'h60, 1, 0));
        vq.push_back(v(1, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0));

        // Outputs are {start, data, busy, ovf, done, addr} after the edge sampling each row
        foreach (vq[i]) begin
            rst             = vq[i].rst;
            bus.iECHO_valid = vq[i].ev;
            bus.iECHO_data  = vq[i].ed;
            bus.iMSG_req    = vq[i].mreq;
            man_busy        = vq[i].busy;
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d]", i),
                  {17'd0, bus.oTX_start, bus.oTX_data, bus.oBusy, bus.oECHO_ovf,
                   bus.oMSG_done, bus.oMSG_addr},
                  {17'd0, vq[i].s, vq[i].d, vq[i].b, vq[i].o, 1'b0, 3'd0});
        end
        bus.iECHO_valid = 1'b0;
        bus.iMSG_req    = 1'b0;
        man_busy        = 1'b0;
        tx_mode         = MODEL;
        tick();

        // Single echo byte against the 20-cycle TX model
        base = tx_log.size();
        k = cyc;
        strobe_echo(8'h41);
        wait_idle(100, "echo_idle");
        check("echo_starts", tx_log.size() - base, 1);
        check("echo_byte", {24'd0, tx_log[base]}, 32'h41);
        check("echo_latency", start_cyc[base] - k, 2);

        // Full status message
        base  = tx_log.size();
        dbase = done_cnt;
        k = cyc;
        strobe_msg();
        wait_done(1000, "msg_done_wait");
        check("msg_addr_wrap", {29'd0, bus.oMSG_addr}, 32'd0);
        check("msg_busy_clear", {31'd0, bus.oBusy}, 32'd0);
        check("msg_starts", tx_log.size() - base, 8);
        for (int unsigned i = 0; i < 8; i++)
            check($sformatf("msg_byte[%0d]", i), {24'd0, tx_log[base+i]}, {24'd0, msg_exp[i]});
        check("msg_latency", start_cyc[base] - k, 4);
        tick();
        check("msg_done_once", done_cnt - dbase, 1);

        // Echo interleaved into a running message
        base = tx_log.size();
        strobe_msg();
        wait_log(base + 2, 200, "mix_wait_byte1");
        strobe_echo(8'h58);
        wait_done(1000, "mix_done_wait");
        check("mix_starts", tx_log.size() - base, 9);
        for (int unsigned i = 0; i < 9; i++)
            check($sformatf("mix_byte[%0d]", i), {24'd0, tx_log[base+i]}, {24'd0, c_exp[i]});

        // Transmitter never acknowledges; repeated request mid-message is ignored
        tx_mode = NEVER;
        tick();
        base  = tx_log.size();
        dbase = done_cnt;
        strobe_msg();
        wait_log(base + 3, 200, "tmo_wait_byte2");
        strobe_msg();
        wait_done(600, "tmo_done_wait");
        check("tmo_spacing", start_cyc[base+1] - start_cyc[base], 20);
        for (int unsigned i = 0; i < 8; i++)
            check($sformatf("tmo_byte[%0d]", i), {24'd0, tx_log[base+i]}, {24'd0, msg_exp[i]});
        repeat (40) tick();
        check("tmo_starts", tx_log.size() - base, 8);
        check("tmo_done_once", done_cnt - dbase, 1);
        check("tmo_busy_clear", {31'd0, bus.oBusy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
